mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates the read/write port of the team's dual-port byte-masked SRAM macro between two requesters, A and B.
- Arbitration is round-robin. A sequencer zero-fills the whole array after reset and on an IN_clear command.
- Read data returns on a shared response bus, tagged with the requester id, at the macro's fixed 2-cycle latency.
- Sits between the SRAM wrapper and its clients. The macro's read-only second port is not touched.

Parameters:
- WORD_SIZE, 32, data width in bits; multiple of 8.
- NUM_WORDS, 1024, memory depth; address width AW = $clog2(NUM_WORDS).
- CLEAR_ON_RESET, 1, 1 = enter CLEAR after reset deassertion; 0 = enter RUN directly.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- IN_clear  in  1  one-cycle pulse; start a zero-fill (honoured in RUN only).
- OUT_busy  out  1  high while the state is CLEAR.
- IN_reqA_valid  in  1  requester A has a request.
- OUT_reqA_ready  out  1  A granted this cycle.
- IN_reqA_we  in  1  1 = write, 0 = read.
- IN_reqA_addr  in  AW  word address.
- IN_reqA_data  in  WORD_SIZE  write data.
- IN_reqA_wm  in  WORD_SIZE/8  byte write mask, bit i enables byte i.
- IN_reqB_valid, OUT_reqB_ready, IN_reqB_we, IN_reqB_addr, IN_reqB_data, IN_reqB_wm: as for A.
- OUT_rsp_valid  out  1  read data valid this cycle.
- OUT_rsp_id  out  1  0 = A, 1 = B.
- OUT_rsp_data  out  WORD_SIZE  read data.
- OUT_mem_nce  out  1  macro chip enable, active low.
- OUT_mem_nwe  out  1  macro write enable, active low.
- OUT_mem_addr  out  AW  macro address.
- OUT_mem_data  out  WORD_SIZE  macro write data.
- OUT_mem_wm  out  WORD_SIZE/8  macro byte mask.
- IN_mem_data  in  WORD_SIZE  macro read data.

Behaviour:
- States: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, else RUN.
  - Reset also sets clr_addr = 0, rr_last = B (so A wins the first tie) and clears both response pipeline stages.
- CLEAR: one write per cycle.
  - Drive nce = 0, nwe = 0, addr = clr_addr, data = 0, wm = all ones; clr_addr increments each cycle.
  - The cycle that issues address NUM_WORDS-1 is the last CLEAR cycle. The next cycle is RUN, with clr_addr reset to 0.
  - CLEAR lasts exactly NUM_WORDS cycles.
  - Both ready outputs are 0 and IN_clear is ignored during CLEAR.
- RUN: grant is combinational and made in the same cycle as the request.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not rr_last.
  - rr_last updates to the granted id on every grant.
  - The granted requester's ready = 1; the other ready = 0.
  - On a grant the macro is driven with nce = 0, nwe = !we, and the requester's addr, data and wm.
- Macro outputs when there is no grant: nce = 1, nwe = 1, addr = 0, data = 0, wm = 0. These are also the values during reset.
- IN_clear in RUN:
  - If IN_clear is asserted, no grant is made that cycle (both ready = 0).
  - CLEAR starts the next cycle.
- A requester must hold valid and its payload stable until ready.
- Read latency:
  - A read granted in cycle t produces OUT_rsp_valid = 1 in cycle t+2, with OUT_rsp_id equal to the granted id.
  - The pipeline is two registered stages (valid, id).
  - OUT_rsp_data = IN_mem_data, a passthrough.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses in grant order.
- Reads still in flight when CLEAR starts are delivered normally. Their data is the pre-clear contents.
- Read-after-write to the same address in consecutive grants returns the new data, because the macro commits the write before the later read.
- Reset asserted mid-operation: outputs take their reset values immediately. Pipelined responses are dropped (no OUT_rsp_valid after reset).
- Reset values:
  - OUT_busy = CLEAR_ON_RESET.
  - Both ready = 0.
  - OUT_rsp_valid = 0, OUT_rsp_id = 0.
  - Macro outputs at their no-grant values.

Test Plan:
- Reset with NUM_WORDS = 16, CLEAR_ON_RESET = 1 -> OUT_busy high for exactly 16 cycles; addresses 0..15 written with data 0 and wm = 4'hF; readies stay 0; then RUN.
- A writes 0xDEADBEEF to addr 5 with wm = 4'hF; next cycle A reads addr 5 -> rsp_valid and rsp_id = 0 two cycles after the read grant, data 0xDEADBEEF.
- A and B both valid continuously, reads of addrs 1 and 2 -> grants alternate A, B, A, B, with A first after reset; responses alternate ids with 2-cycle latency and no gaps.
- B writes 0x11223344 with wm = 4'b0101 over 0xAABBCCDD at addr 3 -> a later read returns 0xAA22CC44.
- IN_clear pulse while a read is in flight -> that response is still delivered with the old data; busy then rises for NUM_WORDS cycles; a read afterwards returns 0.
- rst_n asserted one cycle after a read grant -> no OUT_rsp_valid is produced; nce = 1 immediately.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request, response and SRAM-macro signals of the
// two-requester memory port arbiter.
//   Requester A/B : IN_reqX_valid/we/addr/data/wm in, OUT_reqX_ready out
//   Response      : OUT_rsp_valid, OUT_rsp_id, OUT_rsp_data
//   Macro port    : OUT_mem_nce/nwe/addr/data/wm out, IN_mem_data in
// The slave modport is the arbiter's view; master is the clients/macro side.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024
);
  localparam int AW  = $clog2(NUM_WORDS);
  localparam int WMW = WORD_SIZE / 8;

  logic                 IN_reqA_valid;
  logic                 OUT_reqA_ready;
  logic                 IN_reqA_we;
  logic [AW-1:0]        IN_reqA_addr;
  logic [WORD_SIZE-1:0] IN_reqA_data;
  logic [WMW-1:0]       IN_reqA_wm;

  logic                 IN_reqB_valid;
  logic                 OUT_reqB_ready;
  logic                 IN_reqB_we;
  logic [AW-1:0]        IN_reqB_addr;
  logic [WORD_SIZE-1:0] IN_reqB_data;
  logic [WMW-1:0]       IN_reqB_wm;

  logic                 OUT_rsp_valid;
  logic                 OUT_rsp_id;
  logic [WORD_SIZE-1:0] OUT_rsp_data;

  logic                 OUT_mem_nce;
  logic                 OUT_mem_nwe;
  logic [AW-1:0]        OUT_mem_addr;
  logic [WORD_SIZE-1:0] OUT_mem_data;
  logic [WMW-1:0]       OUT_mem_wm;
  logic [WORD_SIZE-1:0] IN_mem_data;

  modport slave (
    input  IN_reqA_valid, IN_reqA_we, IN_reqA_addr, IN_reqA_data, IN_reqA_wm,
    input  IN_reqB_valid, IN_reqB_we, IN_reqB_addr, IN_reqB_data, IN_reqB_wm,
    input  IN_mem_data,
    output OUT_reqA_ready, OUT_reqB_ready,
    output OUT_rsp_valid, OUT_rsp_id, OUT_rsp_data,
    output OUT_mem_nce, OUT_mem_nwe, OUT_mem_addr, OUT_mem_data, OUT_mem_wm
  );

  modport master (
    output IN_reqA_valid, IN_reqA_we, IN_reqA_addr, IN_reqA_data, IN_reqA_wm,
    output IN_reqB_valid, IN_reqB_we, IN_reqB_addr, IN_reqB_data, IN_reqB_wm,
    output IN_mem_data,
    input  OUT_reqA_ready, OUT_reqB_ready,
    input  OUT_rsp_valid, OUT_rsp_id, OUT_rsp_data,
    input  OUT_mem_nce, OUT_mem_nwe, OUT_mem_addr, OUT_mem_data, OUT_mem_wm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter for the read/write port of the
// byte-masked SRAM macro, with a zero-fill sequencer and a 2-cycle tagged
// read response pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   IN_clear   : one-cycle pulse, start a zero-fill (honoured in RUN only)
//   OUT_busy   : high while the array is being zero-filled
//   bus        : requesters A/B, response bus and macro port (slave modport)
module mem_port_arbiter #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_WORDS      = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic IN_clear,
  output logic OUT_busy,
  mem_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          rr_last_q, rr_last_d;   // 0 = A, 1 = B
  logic          s1_valid_q, s1_valid_d;
  logic          s1_id_q, s1_id_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_id_q, s2_id_d;

  logic gnt_a, gnt_b, gnt_we;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      rr_last_q  <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rr_last_q  <= rr_last_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rr_last_d  = rr_last_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (IN_clear) state_d = ST_CLEAR;
      end
    endcase
    if (gnt_a)      rr_last_d = 1'b0;
    else if (gnt_b) rr_last_d = 1'b1;
    s1_valid_d = (gnt_a | gnt_b) & ~gnt_we;
    s1_id_d    = gnt_b;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
  end

  // Output logic: grant and macro drive. Gated by rst_n so the macro and
  // readies show their idle values for the whole time reset is held, not
  // just from the next edge.
  always_comb begin
    gnt_a            = 1'b0;
    gnt_b            = 1'b0;
    gnt_we           = 1'b0;
    bus.OUT_mem_nce  = 1'b1;
    bus.OUT_mem_nwe  = 1'b1;
    bus.OUT_mem_addr = '0;
    bus.OUT_mem_data = '0;
    bus.OUT_mem_wm   = '0;
    if (rst_n) begin
      unique case (state_q)
        ST_CLEAR: begin
          bus.OUT_mem_nce  = 1'b0;
          bus.OUT_mem_nwe  = 1'b0;
          bus.OUT_mem_addr = clr_addr_q;
          bus.OUT_mem_data = '0;
          bus.OUT_mem_wm   = '1;
        end
        ST_RUN: begin
          if (!IN_clear) begin
            // On a tie the requester that was not granted last wins.
            gnt_a = bus.IN_reqA_valid & (~bus.IN_reqB_valid | rr_last_q);
            gnt_b = bus.IN_reqB_valid & (~bus.IN_reqA_valid | ~rr_last_q);
          end
          if (gnt_a) begin
            gnt_we           = bus.IN_reqA_we;
            bus.OUT_mem_nce  = 1'b0;
            bus.OUT_mem_nwe  = ~bus.IN_reqA_we;
            bus.OUT_mem_addr = bus.IN_reqA_addr;
            bus.OUT_mem_data = bus.IN_reqA_data;
            bus.OUT_mem_wm   = bus.IN_reqA_wm;
          end else if (gnt_b) begin
            gnt_we           = bus.IN_reqB_we;
            bus.OUT_mem_nce  = 1'b0;
            bus.OUT_mem_nwe  = ~bus.IN_reqB_we;
            bus.OUT_mem_addr = bus.IN_reqB_addr;
            bus.OUT_mem_data = bus.IN_reqB_data;
            bus.OUT_mem_wm   = bus.IN_reqB_wm;
          end
        end
      endcase
    end
  end

  assign OUT_busy           = (state_q == ST_CLEAR);
  assign bus.OUT_reqA_ready = gnt_a;
  assign bus.OUT_reqB_ready = gnt_b;
  assign bus.OUT_rsp_valid  = s2_valid_q;
  assign bus.OUT_rsp_id     = s2_id_q;
  assign bus.OUT_rsp_data   = bus.IN_mem_data;
endmodule
